// File: rtl/display_driver_multi.sv
// display_driver_multi: memory-mapped multi-digit 7-segment display controller
// for the CPU data bus. Hex or decimal (sequential double-dabble) display,
// per-digit decimal points, status readback.
// Optional feature macro: DISPLAY_BLINK_EN (CTRL bit2 blink with BLINK_DIV half-period).
// Ports:
//   CLK     system clock, rising edge
//   RST     asynchronous active-high reset
//   WE/A/D  bus write enable, word address, write data
//   RD      combinational bus read data (0 for unmapped addresses)
//   BUSY    decimal conversion in progress
//   DIGITS  active-low segments, digit i at [8i+7:8i], bit7 = DP
module display_driver_multi #(
    parameter int unsigned NUM_DIGITS = 6,
    parameter int unsigned BIN_W      = 20,
    parameter logic [31:0] BASE_ADDR  = 32'hFFFFFFF0,
    parameter int unsigned BLINK_DIV  = 25000000
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    WE,
    input  logic [31:0]             A,
    input  logic [31:0]             D,
    output logic [31:0]             RD,
    output logic                    BUSY,
    output logic [8*NUM_DIGITS-1:0] DIGITS
);

    localparam int unsigned BCD_W      = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W      = $clog2(BIN_W + 1);
    localparam logic [31:0] ADDR_VALUE = BASE_ADDR;
    localparam logic [31:0] ADDR_CTRL  = BASE_ADDR + 32'd1;
    localparam logic [31:0] ADDR_DP    = BASE_ADDR + 32'd2;
    localparam logic [31:0] ADDR_STAT  = BASE_ADDR + 32'd3;

    typedef enum logic {S_IDLE, S_CONV} state_t;

    state_t                  state_q, state_d;
    logic [31:0]             value_q, value_d;
    logic                    on_q, on_d;
    logic                    dec_q, dec_d;
    logic [NUM_DIGITS-1:0]   dp_q, dp_d;
    logic                    busy_q, busy_d;
    logic                    ovf_q, ovf_d;
    logic [BCD_W-1:0]        bcd_q, bcd_d;     // committed result
    logic [BCD_W-1:0]        work_q, work_d;   // in-flight BCD accumulator
    logic [BIN_W-1:0]        bin_q, bin_d;     // remaining binary bits, MSB first
    logic                    wovf_q, wovf_d;   // conversion-local overflow
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    logic                    wr_value, wr_ctrl, wr_dp;
    logic                    start, abort;
    logic [BCD_W-1:0]        adj, shifted;
    logic                    out_bit;
    logic                    blink_bit;
    logic                    blank;

`ifdef DISPLAY_BLINK_EN
    localparam int unsigned BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    logic                    blink_q, blink_d;
    logic                    phase_q, phase_d;  // 1 = blanked half-period
    logic [BCW-1:0]          bcnt_q, bcnt_d;
`endif

    function automatic logic [7:0] enc(input logic [3:0] n);
        case (n)
            4'h0: enc = 8'hC0;  4'h1: enc = 8'hF9;  4'h2: enc = 8'hA4;  4'h3: enc = 8'hB0;
            4'h4: enc = 8'h99;  4'h5: enc = 8'h92;  4'h6: enc = 8'h82;  4'h7: enc = 8'hF8;
            4'h8: enc = 8'h80;  4'h9: enc = 8'h90;  4'hA: enc = 8'h88;  4'hB: enc = 8'h83;
            4'hC: enc = 8'hC6;  4'hD: enc = 8'hA1;  4'hE: enc = 8'h86;  default: enc = 8'h8E;
        endcase
    endfunction

    // Bus decode, register writes, conversion sequencing
    always_comb begin
        state_d = state_q;
        value_d = value_q;
        on_d    = on_q;
        dec_d   = dec_q;
        dp_d    = dp_q;
        busy_d  = busy_q;
        ovf_d   = ovf_q;
        bcd_d   = bcd_q;
        work_d  = work_q;
        bin_d   = bin_q;
        wovf_d  = wovf_q;
        cnt_d   = cnt_q;

        wr_value = WE && (A == ADDR_VALUE);
        wr_ctrl  = WE && (A == ADDR_CTRL);
        wr_dp    = WE && (A == ADDR_DP);

        if (wr_value) value_d = D;
        if (wr_ctrl) begin
            on_d  = D[0];
            dec_d = D[1];
        end
        if (wr_dp) dp_d = D[NUM_DIGITS-1:0];

        // One double-dabble step: add 3 to digits >= 5, then shift in next binary bit
        adj = work_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (adj[4*i +: 4] >= 4'd5) adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
        end
        out_bit = adj[BCD_W-1];
        shifted = {adj[BCD_W-2:0], bin_q[BIN_W-1]};

        if (state_q == S_CONV) begin
            work_d = shifted;
            bin_d  = bin_q << 1;
            wovf_d = wovf_q | out_bit;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
                bcd_d   = shifted;
                ovf_d   = wovf_q | out_bit;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        end

        start = (wr_value && dec_q) || (wr_ctrl && !dec_q && D[1]);
        abort = wr_ctrl && dec_q && !D[1] && (state_q == S_CONV);

        // Start/restart and abort both discard any commit on this edge
        if (start) begin
            state_d = S_CONV;
            busy_d  = 1'b1;
            cnt_d   = '0;
            work_d  = '0;
            wovf_d  = 1'b0;
            bin_d   = wr_value ? D[BIN_W-1:0] : value_q[BIN_W-1:0];
            bcd_d   = bcd_q;
            ovf_d   = ovf_q;
        end else if (abort) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            bcd_d   = bcd_q;
            ovf_d   = ovf_q;
        end
    end

`ifdef DISPLAY_BLINK_EN
    // Blink phase counter; held at visible/0 while blink disabled or being cleared
    always_comb begin
        blink_d = blink_q;
        phase_d = phase_q;
        bcnt_d  = bcnt_q;
        if (wr_ctrl) blink_d = D[2];
        if (!blink_q || !blink_d) begin
            bcnt_d  = '0;
            phase_d = 1'b0;
        end else if (bcnt_q == BCW'(BLINK_DIV - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
        end else begin
            bcnt_d  = bcnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            blink_q <= 1'b0;
            phase_q <= 1'b0;
            bcnt_q  <= '0;
        end else begin
            blink_q <= blink_d;
            phase_q <= phase_d;
            bcnt_q  <= bcnt_d;
        end
    end

    assign blink_bit = blink_q;
    assign blank     = phase_q;
`else
    assign blink_bit = 1'b0;
    assign blank     = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            value_q <= '0;
            on_q    <= 1'b1;
            dec_q   <= 1'b0;
            dp_q    <= '0;
            busy_q  <= 1'b0;
            ovf_q   <= 1'b0;
            bcd_q   <= '0;
            work_q  <= '0;
            bin_q   <= '0;
            wovf_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            value_q <= value_d;
            on_q    <= on_d;
            dec_q   <= dec_d;
            dp_q    <= dp_d;
            busy_q  <= busy_d;
            ovf_q   <= ovf_d;
            bcd_q   <= bcd_d;
            work_q  <= work_d;
            bin_q   <= bin_d;
            wovf_q  <= wovf_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BUSY = busy_q;

    // Read mux
    always_comb begin
        RD = '0;
        case (A)
            ADDR_VALUE: RD = value_q;
            ADDR_CTRL:  RD = {29'd0, blink_bit, dec_q, on_q};
            ADDR_DP:    RD = 32'(dp_q);
            ADDR_STAT:  RD = {30'd0, ovf_q, busy_q};
            default:    RD = '0;
        endcase
    end

    // Segment output: off / blink-blank, else overflow dash or digit, DP overlay
    always_comb begin
        DIGITS = '1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (on_q && !blank) begin
                DIGITS[8*i +: 8] = ovf_q ? 8'hBF
                                         : enc(dec_q ? bcd_q[4*i +: 4] : value_q[4*i +: 4]);
                if (dp_q[i]) DIGITS[8*i+7] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_display_driver_multi.sv
module tb_display_driver_multi;

    localparam int unsigned ND   = 6;
    localparam logic [31:0] BASE = 32'hFFFFFFF0;

    logic            CLK = 1'b0;
    logic            RST = 1'b1;
    logic            WE  = 1'b0;
    logic [31:0]     A   = '0;
    logic [31:0]     D   = '0;
    logic [31:0]     RD;
    logic            BUSY;
    logic [8*ND-1:0] DIGITS;

    display_driver_multi #(
        .NUM_DIGITS(ND),
        .BIN_W(20),
        .BASE_ADDR(BASE),
        .BLINK_DIV(4)
    ) dut (
        .CLK(CLK), .RST(RST), .WE(WE), .A(A), .D(D),
        .RD(RD), .BUSY(BUSY), .DIGITS(DIGITS)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int          cyc;
        int          kind;   // 0 DIGITS, 1 RD, 2 BUSY
        logic [63:0] exp;
        string       name;
    } chk_t;

    chk_t sb[$];
    int   cyc   = 0;
    int   n_vec = 0;
    int   n_bad = 0;

    always @(posedge CLK) cyc <= cyc + 1;

    // Monitor: pops every expectation due this cycle and compares on the falling edge
    always @(negedge CLK) begin
        chk_t        it;
        logic [63:0] act;
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            it = sb.pop_front();
            case (it.kind)
                0:       act = 64'(DIGITS);
                1:       act = 64'(RD);
                default: act = 64'(BUSY);
            endcase
            n_vec++;
            if (it.cyc != cyc || act !== it.exp) begin
                n_bad++;
                $display("FAIL %s: got %h want %h (cycle %0d, due %0d)",
                         it.name, act, it.exp, cyc, it.cyc);
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic push(input int kind, input logic [63:0] exp, input string name);
        chk_t it;
        it.cyc  = cyc;
        it.kind = kind;
        it.exp  = exp;
        it.name = name;
        sb.push_back(it);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        WE = 1'b1;
        A  = addr;
        D  = data;
        tick();
        WE = 1'b0;
        A  = '0;
    endtask

    task automatic exp_dig(input logic [47:0] v, input string name);
        push(0, 64'(v), name);
    endtask

    task automatic exp_busy(input logic v, input string name);
        push(2, 64'(v), name);
    endtask

    task automatic exp_rd(input logic [31:0] addr, input logic [31:0] v, input string name);
        A = addr;
        push(1, 64'(v), name);
        tick();
        A = '0;
    endtask

    function automatic logic [47:0] rep(input logic [7:0] b);
        return {6{b}};
    endfunction

    initial begin
        // Reset state
        RST = 1'b1;
        repeat (2) tick();
        exp_dig(rep(8'hC0), "rst_digits");
        exp_busy(1'b0, "rst_busy");
        tick();
        RST = 1'b0;
        tick();
        exp_rd(BASE + 32'd1, 32'h1, "rst_ctrl");
        exp_rd(BASE + 32'd3, 32'h0, "rst_status");
        exp_rd(BASE, 32'h0, "rst_value");

        // Hex mode and decimal points
        wr(BASE, 32'h00123456);
        exp_dig(48'hF9A4B0999282, "hex_digits");
        exp_rd(BASE, 32'h00123456, "hex_value_rd");
        wr(BASE + 32'd2, 32'h1);
        exp_dig(48'hF9A4B0999202, "hex_dp0");
        exp_rd(BASE + 32'd2, 32'h1, "dp_rd");
        wr(BASE + 32'd2, 32'h0);

        // Ignored writes and unmapped reads
        wr(BASE + 32'd3, 32'hFFFFFFFF);
        exp_rd(BASE + 32'd3, 32'h0, "status_ro");
        wr(BASE - 32'd1, 32'hDEADBEEF);
        exp_rd(BASE - 32'd1, 32'h0, "unmapped_rd");
        exp_rd(BASE, 32'h00123456, "unmapped_no_write");

        // Display off
        wr(BASE + 32'd1, 32'h0);
        exp_dig(rep(8'hFF), "off_blank");
        exp_rd(BASE + 32'd1, 32'h0, "off_ctrl");
        wr(BASE + 32'd1, 32'h1);

        // Decimal 999999 (restarts the conversion begun by the CTRL write)
        wr(BASE + 32'd1, 32'h3);
        wr(BASE, 32'd999999);
        for (int k = 0; k < 20; k++) begin
            exp_busy(1'b1, "dec_busy");
            exp_dig(rep(8'hC0), "dec_hold_prev");
            tick();
        end
        exp_busy(1'b0, "dec_done");
        exp_dig(rep(8'h90), "dec_999999");
        exp_rd(BASE + 32'd3, 32'h0, "dec_status");

        // Overflow
        wr(BASE, 32'd1000000);
        for (int k = 0; k < 20; k++) begin
            exp_busy(1'b1, "ovf_busy");
            exp_dig(rep(8'h90), "ovf_hold_prev");
            tick();
        end
        exp_busy(1'b0, "ovf_done");
        exp_dig(rep(8'hBF), "ovf_dash");
        exp_rd(BASE + 32'd3, 32'h2, "ovf_status");

        // Recover with 42
        wr(BASE, 32'd42);
        for (int k = 0; k < 20; k++) begin
            exp_dig(rep(8'hBF), "d42_hold_prev");
            tick();
        end
        exp_dig(48'hC0C0C0C099A4, "d42_digits");
        exp_rd(BASE + 32'd3, 32'h0, "d42_status");

        // Restart: 123 then 7 on the fifth conversion cycle
        wr(BASE, 32'd123);
        for (int k = 0; k < 4; k++) begin
            exp_dig(48'hC0C0C0C099A4, "rs_hold_a");
            tick();
        end
        wr(BASE, 32'd7);
        for (int k = 0; k < 20; k++) begin
            exp_busy(1'b1, "rs_busy");
            exp_dig(48'hC0C0C0C099A4, "rs_hold_b");
            tick();
        end
        exp_busy(1'b0, "rs_done");
        exp_dig(48'hC0C0C0C0C0F8, "rs_digits7");

        // Abort via DEC 1->0
        wr(BASE, 32'd555);
        repeat (3) tick();
        wr(BASE + 32'd1, 32'h1);
        exp_busy(1'b0, "abort_busy");
        exp_dig(48'hC0C0C0A4A483, "abort_hex");
        exp_rd(BASE + 32'd3, 32'h0, "abort_status");

        // Conversion continues while ON=0
        wr(BASE + 32'd1, 32'h3);
        repeat (2) tick();
        wr(BASE + 32'd1, 32'h2);
        exp_dig(rep(8'hFF), "conv_off_blank");
        exp_busy(1'b1, "conv_off_busy");
        repeat (17) tick();
        exp_busy(1'b0, "conv_off_done");
        wr(BASE + 32'd1, 32'h3);
        exp_dig(48'hC0C0C0929292, "conv_off_555");
        exp_busy(1'b0, "conv_off_no_restart");

        // Reset mid-conversion
        wr(BASE, 32'd999);
        repeat (3) tick();
        RST = 1'b1;
        #1;
        exp_dig(rep(8'hC0), "rst2_digits");
        exp_busy(1'b0, "rst2_busy");
        tick();
        RST = 1'b0;
        tick();
        exp_rd(BASE + 32'd1, 32'h1, "rst2_ctrl");
        exp_rd(BASE + 32'd3, 32'h0, "rst2_status");
        exp_rd(BASE, 32'h0, "rst2_value");
        repeat (25) tick();
        exp_dig(rep(8'hC0), "rst2_no_commit");

`ifdef DISPLAY_BLINK_EN
        wr(BASE + 32'd1, 32'h5);
        for (int k = 0; k < 16; k++) begin
            exp_dig(((k / 4) % 2 == 1) ? rep(8'hFF) : rep(8'hC0), "blink_phase");
            tick();
        end
        wr(BASE + 32'd1, 32'h1);
        for (int k = 0; k < 8; k++) begin
            exp_dig(rep(8'hC0), "blink_steady");
            tick();
        end
`else
        wr(BASE + 32'd1, 32'h5);
        exp_rd(BASE + 32'd1, 32'h1, "noblink_ctrl");
        for (int k = 0; k < 8; k++) begin
            exp_dig(rep(8'hC0), "noblink_steady");
            tick();
        end
`endif

        repeat (2) tick();
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
